// File: rtl/move_sequencer.sv
// Turn controller for the Othello board store: latch a move, then run detect, write and redraw.
// Optional idle auto-pass is built when MOVE_TIMEOUT_EN is defined.
module move_sequencer #(
    parameter int DET_CYCLES     = 8,
    parameter int WR_CYCLES      = 8,
    parameter int PLOT_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       move_req,
    input  logic [2:0] move_x,
    input  logic [2:0] move_y,
    input  logic       pass_req,
    input  logic [7:0] dir,
    output logic [2:0] ram_x,
    output logic [2:0] ram_y,
    output logic       side,
    output logic       detecten,
    output logic       writeen,
    output logic       en_plot,
    output logic       ready,
    output logic       move_ok,
    output logic       move_bad,
    output logic       timeout,
    output logic [6:0] move_count,
    output logic       game_over
);

    localparam int DET_N  = (DET_CYCLES  < 1) ? 1 : DET_CYCLES;
    localparam int WR_N   = (WR_CYCLES   < 1) ? 1 : WR_CYCLES;
    localparam int PLOT_N = (PLOT_CYCLES < 1) ? 1 : PLOT_CYCLES;
    localparam int MAX_A  = (DET_N > WR_N) ? DET_N : WR_N;
    localparam int MAX_N  = (MAX_A > PLOT_N) ? MAX_A : PLOT_N;
    localparam int CNT_W  = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {IDLE, DETECT, EVAL, WRITE, PLOT} state_t;

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [1:0]       pass_streak;

`ifdef MOVE_TIMEOUT_EN
    localparam int TMO_N = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int TMO_W = $clog2(TMO_N + 1);

    logic [TMO_W-1:0] idle_cnt;
    logic             tmo_hit;

    assign tmo_hit = (state == IDLE) && !game_over && (idle_cnt == TMO_W'(TMO_N - 1));

    always_ff @(posedge clock) begin
        if (resetn) begin
            idle_cnt <= '0;
        end else if (state == IDLE && !game_over) begin
            if (move_req || pass_req || tmo_hit)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (resetn) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            pass_streak <= '0;
            ram_x       <= '0;
            ram_y       <= '0;
            side        <= 1'b0;
            detecten    <= 1'b0;
            writeen     <= 1'b0;
            en_plot     <= 1'b0;
            ready       <= 1'b1;
            move_ok     <= 1'b0;
            move_bad    <= 1'b0;
            move_count  <= '0;
            game_over   <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
        end else begin
            move_ok  <= 1'b0;
            move_bad <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!game_over) begin
                        if (move_req) begin
                            ram_x     <= move_x;
                            ram_y     <= move_y;
                            ready     <= 1'b0;
                            detecten  <= 1'b1;
                            phase_cnt <= CNT_W'(DET_N - 1);
                            state     <= DETECT;
                        end else if (pass_req) begin
                            side        <= ~side;
                            pass_streak <= (pass_streak == 2'd2) ? 2'd2 : pass_streak + 2'd1;
                            if (pass_streak == 2'd1)
                                game_over <= 1'b1;
                        end
`ifdef MOVE_TIMEOUT_EN
                        else if (tmo_hit) begin
                            side        <= ~side;
                            timeout     <= 1'b1;
                            pass_streak <= (pass_streak == 2'd2) ? 2'd2 : pass_streak + 2'd1;
                            if (pass_streak == 2'd1)
                                game_over <= 1'b1;
                        end
`endif
                    end
                end
                DETECT: begin
                    if (phase_cnt == '0) begin
                        detecten <= 1'b0;
                        state    <= EVAL;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                EVAL: begin
                    if (|dir) begin
                        writeen   <= 1'b1;
                        phase_cnt <= CNT_W'(WR_N - 1);
                        state     <= WRITE;
                    end else begin
                        move_bad <= 1'b1;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end
                end
                WRITE: begin
                    if (phase_cnt == '0) begin
                        writeen   <= 1'b0;
                        en_plot   <= 1'b1;
                        phase_cnt <= CNT_W'(PLOT_N - 1);
                        state     <= PLOT;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                PLOT: begin
                    if (phase_cnt == '0) begin
                        en_plot     <= 1'b0;
                        move_ok     <= 1'b1;
                        ready       <= 1'b1;
                        side        <= ~side;
                        pass_streak <= '0;
                        if (move_count != 7'd127)
                            move_count <= move_count + 7'd1;
                        if (move_count == 7'd59)
                            game_over <= 1'b1;
                        state <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                default: begin
                    detecten <= 1'b0;
                    writeen  <= 1'b0;
                    en_plot  <= 1'b0;
                    ready    <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: stimulus queues expected pulses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_move_sequencer;

`ifdef MOVE_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 1000000;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       move_req = 1'b0;
    logic [2:0] move_x = '0;
    logic [2:0] move_y = '0;
    logic       pass_req = 1'b0;
    logic [7:0] dir = '0;
    logic [2:0] ram_x, ram_y;
    logic       side, detecten, writeen, en_plot, ready;
    logic       move_ok, move_bad, timeout, game_over;
    logic [6:0] move_count;

    move_sequencer #(
        .DET_CYCLES(8),
        .WR_CYCLES(8),
        .PLOT_CYCLES(64),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .resetn(resetn), .move_req(move_req), .move_x(move_x),
        .move_y(move_y), .pass_req(pass_req), .dir(dir), .ram_x(ram_x), .ram_y(ram_y),
        .side(side), .detecten(detecten), .writeen(writeen), .en_plot(en_plot),
        .ready(ready), .move_ok(move_ok), .move_bad(move_bad), .timeout(timeout),
        .move_count(move_count), .game_over(game_over)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // kind: 0 = move_ok, 1 = move_bad, 2 = timeout; lat < 0 skips the latency check
    typedef struct {
        int   kind;
        logic side;
        int   count;
        int   lat;
        int   acc;
        int   det;
        int   wr;
        int   plot;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    int   det_n = 0, wr_n = 0, plot_n = 0, ev_kind = 0;
    exp_t e;

    always @(negedge clock) begin
        if (resetn) begin
            det_n = 0; wr_n = 0; plot_n = 0;
        end else begin
            if (detecten || writeen || en_plot)
                check("strobe_excl", int'(detecten) + int'(writeen) + int'(en_plot), 1);
            det_n  += int'(detecten);
            wr_n   += int'(writeen);
            plot_n += int'(en_plot);
            if (move_ok || move_bad || timeout) begin
                ev_kind = move_ok ? 0 : (move_bad ? 1 : 2);
                if (sb.size() == 0) begin
                    check("unexpected_event", ev_kind, -1);
                end else begin
                    e = sb.pop_front();
                    check("ev_kind", ev_kind, e.kind);
                    check("ev_single", int'(move_ok) + int'(move_bad) + int'(timeout), 1);
                    check("ev_side", int'(side), int'(e.side));
                    check("ev_count", int'(move_count), e.count);
                    check("ev_ready", int'(ready), 1);
                    check("ev_det_cycles", det_n, e.det);
                    check("ev_wr_cycles", wr_n, e.wr);
                    check("ev_plot_cycles", plot_n, e.plot);
                    if (e.lat >= 0)
                        check("ev_latency", cyc - e.acc, e.lat);
                end
                det_n = 0; wr_n = 0; plot_n = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", int'(ready), 1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        resetn = 1'b0;
    endtask

    task automatic do_move(input logic [2:0] x, input logic [2:0] y, input logic [7:0] d,
                           input logic with_pass, input int kind, input logic exp_side,
                           input int exp_cnt, input int lat, input int det, input int wr,
                           input int plot);
        wait_ready();
        move_x = x; move_y = y; dir = d;
        move_req = 1'b1; pass_req = with_pass;
        sb.push_back('{kind, exp_side, exp_cnt, lat, cyc, det, wr, plot});
        @(negedge clock);
        move_req = 1'b0; pass_req = 1'b0;
        check("ram_x", int'(ram_x), int'(x));
        check("ram_y", int'(ram_y), int'(y));
        check("ready_busy", int'(ready), 0);
    endtask

    task automatic do_pass(input logic exp_side, input logic exp_go);
        wait_ready();
        pass_req = 1'b1;
        @(negedge clock);
        pass_req = 1'b0;
        check("pass_side", int'(side), int'(exp_side));
        check("pass_game_over", int'(game_over), int'(exp_go));
    endtask

    task automatic ignored_move(input logic exp_side);
        int det_seen = 0;
        move_x = 3'd4; move_y = 3'd4; dir = 8'hff;
        move_req = 1'b1;
        @(negedge clock);
        move_req = 1'b0;
        pass_req = 1'b1;
        @(negedge clock);
        pass_req = 1'b0;
        repeat (12) begin
            det_seen += int'(detecten);
            @(negedge clock);
        end
        check("ignored_detecten", det_seen, 0);
        check("ignored_ready", int'(ready), 1);
        check("ignored_side", int'(side), int'(exp_side));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_ready", int'(ready), 1);
        check("rst_side", int'(side), 0);
        check("rst_count", int'(move_count), 0);
        check("rst_strobes", int'({detecten, writeen, en_plot}), 0);
        check("rst_pulses", int'({move_ok, move_bad, timeout}), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_ram", int'({ram_x, ram_y}), 0);

        do_pass(1'b1, 1'b0);
        do_move(3'd3, 3'd2, 8'h04, 1'b0, 0, 1'b0, 1, 82, 8, 8, 64);
        do_move(3'd0, 3'd0, 8'h00, 1'b0, 1, 1'b0, 1, 10, 8, 0, 0);
        do_move(3'd5, 3'd7, 8'h10, 1'b1, 0, 1'b1, 2, 82, 8, 8, 64);
        do_pass(1'b0, 1'b0);
        do_pass(1'b1, 1'b1);
        ignored_move(1'b1);

        // abort mid-write
        do_reset();
        do_pass(1'b1, 1'b0);
        move_x = 3'd1; move_y = 3'd1; dir = 8'hff;
        move_req = 1'b1;
        @(negedge clock);
        move_req = 1'b0;
        begin
            int n = 0;
            while (!writeen && n < 50) begin
                @(negedge clock);
                n++;
            end
        end
        check("abort_saw_write", int'(writeen), 1);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("abort_writeen", int'(writeen), 0);
        check("abort_ready", int'(ready), 1);
        check("abort_side", int'(side), 0);
        check("abort_count", int'(move_count), 0);
        check("abort_strobes", int'({detecten, en_plot}), 0);
        resetn = 1'b0;

        for (int k = 1; k <= 60; k++)
            do_move(3'(k % 8), 3'((k / 8) % 8), 8'h01, 1'b0, 0, 1'(k % 2), k, 82, 8, 8, 64);
        wait_ready();
        check("sixty_game_over", int'(game_over), 1);
        check("sixty_count", int'(move_count), 60);
        ignored_move(1'b0);

`ifdef MOVE_TIMEOUT_EN
        do_reset();
        sb.push_back('{2, 1'b1, 0, -1, cyc, 0, 0, 0});
        repeat (120) @(negedge clock);
        check("tmo_side", int'(side), 1);
        check("tmo_game_over", int'(game_over), 0);
`endif

        repeat (4) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
